// File: rtl/vec_wb_buffer_if.sv
// vec_wb_buffer_if
// Purpose: bundles the two handshakes of the vector write-back buffer.
//   The ALU-side push channel is in_valid/in_ready/in_vrt/in_tag.
//   The register-file-side drain channel is wb_valid/wb_ready/wb_data/wb_tag.
// Modports:
//   slave  - the buffer itself. It accepts pushes and presents write-backs.
//   master - the surroundings. This is the ALU stage plus the register-file
//            write port, or a testbench standing in for both.
interface vec_wb_buffer_if #(
  parameter int TAGW = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_vrt;
  logic [TAGW-1:0] in_tag;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [TAGW-1:0] wb_tag;

  modport slave (
    input  in_valid, in_vrt, in_tag, wb_ready,
    output in_ready, wb_valid, wb_data, wb_tag
  );

  modport master (
    output in_valid, in_vrt, in_tag, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_tag
  );
endinterface

// File: rtl/vec_wb_buffer.sv
// vec_wb_buffer
// Purpose: a small FIFO for vector ALU results on their way to the register
//   file. Each entry is a 32-bit result word plus its destination tag. The
//   buffer drains one entry per cycle into the write port. It also exports a
//   per-register pending map so issue can stall read-after-write hazards.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; has priority over flush
//   flush  - synchronous discard of every queued entry; drops any push or pop
//            in the same cycle
//   bus    - slave side of the push (in_*) and write-back (wb_*) handshakes
//   pend   - bit t is high while any queued entry targets register t
//   count  - number of occupied entries
module vec_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  vec_wb_buffer_if.slave           bus,
  output logic [(1<<TAGW)-1:0]     pend,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]     data_mem [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic [PW-1:0]   offset;

  // Handshake qualification. in_ready depends only on occupancy, so there is
  // no combinational path from wb_ready through to in_ready.
  always_comb begin
    bus.in_ready = (count < FULL);
    bus.wb_valid = (count != '0);
    bus.wb_data  = data_mem[rd_ptr];
    bus.wb_tag   = tag_mem[rd_ptr];
    push         = bus.in_valid && bus.in_ready;
    pop          = bus.wb_valid && bus.wb_ready;
  end

  // Payload storage has no reset. A slot is only ever read after it has been
  // written. Writes are suppressed during reset and flush, so a dropped push
  // leaves the slot untouched.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      data_mem[wr_ptr] <= bus.in_vrt;
      tag_mem[wr_ptr]  <= bus.in_tag;
    end
  end

  // Pointers and occupancy. Reset and flush share one clear path. A
  // simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending map. A slot is occupied when its distance ahead of the read
  // pointer, taken modulo DEPTH, is less than the occupancy. Duplicate tags
  // simply OR together.
  always_comb begin
    pend   = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ({1'b0, offset} < count) pend[tag_mem[i]] = 1'b1;
    end
  end

endmodule

// File: doc/vec_wb_buffer.md
# vec_wb_buffer

Write-back buffer that sits directly downstream of the byte-modulo vector ALU stages (vsububm and its siblings). It captures each 32-bit vector result with its destination register tag, queues it in a small FIFO, and drains one entry per cycle into the vector register-file write port under a valid/ready handshake. It also exports a per-register pending scoreboard so the issue stage can stall read-after-write hazards on results that have not yet been written back.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TAGW, 3: destination tag width; the register file has 2^TAGW vector registers.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all queued entries.
- in_valid  in  1  result offered by the ALU stage.
- in_ready  out  1  buffer can accept a result this cycle.
- in_vrt  in  32  result word, four packed bytes, stored unmodified.
- in_tag  in  TAGW  destination register index.
- wb_valid  out  1  head entry presented to the register file.
- wb_ready  in  1  register file accepts the head entry.
- wb_data  out  32  head result word.
- wb_tag  out  TAGW  head destination index.
- pend  out  2^TAGW  bit t is 1 while any queued entry has tag t.
- count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH × (32+TAGW) registers, a read pointer and a write pointer, each log2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy counter.
- A push occurs when in_valid and in_ready are both high. The entry is written at the write pointer, and the write pointer increments.
- A pop occurs when wb_valid and wb_ready are both high. The read pointer increments.
- in_ready = (count < DEPTH). It does not depend on wb_ready, so there is no combinational path from wb_ready to in_ready.
- wb_valid = (count != 0). wb_data and wb_tag show the entry at the read pointer and are held stable while wb_valid is high and wb_ready is low.
- When wb_valid is low, wb_data and wb_tag are don't-care. The bench must not check them.
- pend is combinational. For each tag t, pend[t] is the OR over occupied slots of (slot tag == t). Duplicate tags are allowed: pend[t] stays high until the last entry with tag t is popped.
- Push and pop in the same cycle:
  - When 0 < count < DEPTH, both take effect and count is unchanged.
  - When count == 0, only the push occurs, because wb_valid is low.
  - When count == DEPTH, only the pop occurs, because in_ready is low.
- flush takes priority over push and pop in the same cycle. Pointers and count go to 0, and pend goes to all-zero on the next cycle. An in_valid arriving in the flush cycle is dropped, even though in_ready may be high.
- Reset: rst is the same as flush and also takes priority over it.

## Timing
- Outputs after reset: in_ready=1, wb_valid=0, count=0, pend=0, wb_data/wb_tag don't-care. Storage contents are not reset.
- Latency: a push in cycle N is visible at wb_valid/wb_data in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- pend[t] rises in the cycle after the push of tag t. It falls in the cycle after the pop of the last entry holding tag t.
- count updates one cycle after the handshake.
- Wrap-around: after DEPTH pushes, the write pointer returns to 0. Ordering is strictly FIFO across the wrap.

## Test plan
- After reset, push 32'h01020304 with tag 5, holding wb_ready=0 -> next cycle wb_valid=1, wb_data=32'h01020304, wb_tag=5, pend=8'b0010_0000, count=1. These values hold stable until wb_ready=1; the cycle after the pop, wb_valid=0 and pend=0.
- With wb_ready=0, push tags 0,1,2,3 -> count=4, in_ready=0. A fifth in_valid is not accepted. Raise wb_ready -> data drains in order 0,1,2,3, with in_ready=1 in the cycle after the first pop.
- Continuous push and pop with wb_ready=1 over 10 results 32'hFF00FF00+i -> one result out per cycle, in order, across two pointer wraps; count stays at 1.
- Push tag 2 twice, then pop once -> pend[2] stays 1. Pop again -> pend[2]=0 the next cycle.
- Fill to 3 entries, then assert flush together with in_valid and wb_ready -> the next cycle has count=0, wb_valid=0, pend=0, and no entry was added or written back.
- Assert rst mid-stream with 2 entries queued and the pop handshake active -> the next cycle has all outputs at their reset values. A push after rst deasserts appears one cycle later, in correct order.
